shift_chain_checker: RTL and testbench
======================================

// Module: shift_chain_checker
// PURPOSE
//   Synthesizable consumer for the 4-tap nonblocking shift chain (a->b->c->d).
//   Samples the taps every clock edge and checks b(t)=a(t-1), c(t)=b(t-1), d(t)=c(t-1).
//   Reports pass/fail status, counts mismatches and identifies the first failing tap.
//   Sits beside the chain in the sim top and is also usable as an on-chip self-check.
// PARAMETERS
//   WIDTH      32  tap data width
//   CNT_W      16  width of the mismatch and checked counters (saturating)
//   FILL_CYC    1  valid history cycles required before checking starts (min 1)
// PORTS
//   clock          in   1      single clock; all state updates on posedge
//   reset          in   1      asynchronous, active-high reset
//   enable         in   1      1 = sample/check this cycle; 0 = hold all state
//   clear          in   1      synchronous: return to IDLE, zero counters and flags
//   a,b,c,d        in   WIDTH  chain taps, in chain order
//   busy           out  1      FSM in FILL or CHECK
//   pass           out  1      CHECK state and no mismatch since the last clear/reset
//   fail           out  1      sticky; set on the first mismatch
//   first_fail_tap out  2      1=b, 2=c, 3=d; 0 = none; latched with fail
//   mismatch_cnt   out  CNT_W  failing cycles counted; saturates at all-ones
//   checked_cnt    out  CNT_W  compared cycles counted; saturates at all-ones
// BEHAVIOUR
//   Reset (async, any time, mid-check included): state=IDLE, prev_a/b/c=0, every output 0.
//   FSM states: IDLE, FILL, CHECK, FAIL.
//   - IDLE  -> FILL  when enable=1. Capture prev_{a,b,c} <= {a,b,c}. Fill count = 1.
//   - FILL  -> CHECK after FILL_CYC enabled cycles, including the IDLE capture cycle.
//              No compare is made in FILL.
//   - CHECK: each enabled cycle compares {b,c,d} with prev_{a,b,c} and increments checked_cnt.
//     - Any mismatch: go to FAIL; set fail; increment mismatch_cnt.
//     - first_fail_tap = the lowest failing tap.
//   - FAIL: comparing and counting continue; fail and first_fail_tap hold.
//   - prev_{a,b,c} <= {a,b,c} on every enabled cycle in FILL, CHECK and FAIL.
//   enable=0 freezes history, counters and state. The next enabled cycle compares
//     against the last enabled sample (gap-tolerant).
//   Simultaneous events: clear takes priority over enable, so the new sample is
//     discarded. Same-edge mismatch and counter saturation: the counter holds at
//     all-ones and fail still sets.
//   Latency: flags and counters update on the edge that samples the taps. Outputs are
//     registered, so results are visible 1 cycle after the sample.
//   Arithmetic: unsigned compare over the full WIDTH. Counters never wrap.
//   pass = (state==CHECK) && !fail.   busy = (state==FILL || state==CHECK).
// CONFIGURATION
//   `define SHIFT_CHK_TRACE_EN:
//     - adds output ports exp_val[WIDTH-1:0] and act_val[WIDTH-1:0].
//     - captures expected/actual data of the first failing tap; held until clear/reset.
//     - both values reset to 0.
//   Macro undefined: these ports and registers do not exist. All other behaviour is identical.
// STRUCTURE
//   Package shift_chk_pkg:
//     - state_t enum {IDLE, FILL, CHECK, FAIL}
//     - tap-id constants TAP_NONE=0, TAP_B=1, TAP_C=2, TAP_D=3
//     - default WIDTH/CNT_W localparams
//   Sub-module tap_compare:
//     - one instance per tap pair (x3)
//     - inputs exp, act, en; output mis = en & (exp != act)
//   Top level holds the FSM, the history registers, the counters and the priority encoder.
// TESTING
//   1. Correct chain: a=1,2,3... fed through a 1-cycle shift model, 100 cycles
//      -> fail=0, pass=1 from cycle 3, mismatch_cnt=0, checked_cnt=98.
//   2. Corrupt c at cycle 10 (expect 9, drive 99)
//      -> fail=1 at next edge, first_fail_tap=2, mismatch_cnt=1.
//      -> with TRACE_EN: exp_val=9, act_val=99.
//   3. b and d both wrong on the same cycle
//      -> first_fail_tap=1, mismatch_cnt increments by 1 (not 2).
//   4. Hold enable=0 for 5 cycles mid-run with the taps frozen
//      -> counters and fail unchanged. On resume, the correct chain still passes.
//   5. Assert reset asynchronously mid-CHECK, between edges
//      -> all outputs 0 immediately. IDLE->FILL->CHECK resumes after release.
//   6. CNT_W=4 with 20 consecutive mismatches
//      -> mismatch_cnt=15 and holds. clear -> counters 0, state=IDLE, fail=0.

Source files
------------

// File: rtl/shift_chk_pkg.sv
// Shared types and constants for the shift-chain checker.
// Contents: FSM state enum, tap identifiers, default parameter values and a
// priority helper that picks the lowest failing tap.
package shift_chk_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_FILL_CYC = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] TAP_NONE = 2'd0;
    localparam logic [1:0] TAP_B    = 2'd1;
    localparam logic [1:0] TAP_C    = 2'd2;
    localparam logic [1:0] TAP_D    = 2'd3;

    // mis[0]=b, mis[1]=c, mis[2]=d; the tap nearest the chain head wins.
    function automatic logic [1:0] lowest_tap(input logic [2:0] mis);
        logic [1:0] tap;
        tap = TAP_NONE;
        if (mis[0]) begin
            tap = TAP_B;
        end else if (mis[1]) begin
            tap = TAP_C;
        end else if (mis[2]) begin
            tap = TAP_D;
        end
        return tap;
    endfunction

endpackage

// File: rtl/tap_compare.sv
// One tap-pair comparator: flags a mismatch between the expected (previous
// upstream) value and the actual tap value when the compare is enabled.
// Ports:
//   exp_i  in  WIDTH  expected value (previous sample of upstream tap)
//   act_i  in  WIDTH  actual value of the tap under test
//   en_i   in  1      compare enable
//   mis_o  out 1      combinational mismatch flag
module tap_compare
    import shift_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] act_i,
    input  logic             en_i,
    output logic             mis_o
);

    // Full-width unsigned inequality, gated by the enable.
    assign mis_o = en_i & (exp_i != act_i);

endmodule

// File: rtl/shift_chain_checker.sv
// Checker for a 4-tap shift chain a->b->c->d. Each enabled clock it compares
// b, c, d with the previous enabled samples of a, b, c, reports pass/fail,
// counts checked and failing cycles (saturating) and latches the first failing tap.
// Optional build macro SHIFT_CHK_TRACE_EN adds exp_val/act_val, holding the
// expected and actual data of the first failing tap.
// Ports:
//   clock           in   1      clock, posedge
//   reset           in   1      asynchronous active-high reset
//   enable          in   1      sample/check this cycle; 0 holds all state
//   clear           in   1      synchronous return to IDLE, zero counters/flags
//   a, b, c, d      in   WIDTH  chain taps in chain order
//   busy            out  1      FSM in FILL or CHECK
//   pass            out  1      CHECK state with no mismatch seen
//   fail            out  1      sticky mismatch flag
//   first_fail_tap  out  2      1=b, 2=c, 3=d, 0=none
//   mismatch_cnt    out  CNT_W  failing cycles, saturating
//   checked_cnt     out  CNT_W  compared cycles, saturating
//   exp_val/act_val out  WIDTH  (SHIFT_CHK_TRACE_EN only) first-failure data
module shift_chain_checker
    import shift_chk_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned FILL_CYC = DEF_FILL_CYC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       first_fail_tap,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] checked_cnt
`ifdef SHIFT_CHK_TRACE_EN
    ,
    output logic [WIDTH-1:0] exp_val,
    output logic [WIDTH-1:0] act_val
`endif
);

    // Fill counter must be able to hold FILL_CYC itself.
    localparam int unsigned FILL_W = (FILL_CYC < 2) ? 1 : $clog2(FILL_CYC + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_a_q, prev_a_d;
    logic [WIDTH-1:0]   prev_b_q, prev_b_d;
    logic [WIDTH-1:0]   prev_c_q, prev_c_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               fail_q, fail_d;
    logic [1:0]         tap_q, tap_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0]   ccnt_q, ccnt_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
`ifdef SHIFT_CHK_TRACE_EN
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]   act_q, act_d;
`endif

    logic               cmp_en;
    logic [2:0]         mis;
    logic               any_mis;

    // Compares only run on enabled, non-clear cycles once history is valid.
    assign cmp_en = enable & ~clear & ((state_q == CHECK) | (state_q == FAIL));

    tap_compare #(.WIDTH(WIDTH)) u_cmp_b (
        .exp_i (prev_a_q),
        .act_i (b),
        .en_i  (cmp_en),
        .mis_o (mis[0])
    );

    tap_compare #(.WIDTH(WIDTH)) u_cmp_c (
        .exp_i (prev_b_q),
        .act_i (c),
        .en_i  (cmp_en),
        .mis_o (mis[1])
    );

    tap_compare #(.WIDTH(WIDTH)) u_cmp_d (
        .exp_i (prev_c_q),
        .act_i (d),
        .en_i  (cmp_en),
        .mis_o (mis[2])
    );

    assign any_mis = |mis;

    // Next-state, history, counters and flags.
    always_comb begin
        state_d  = state_q;
        prev_a_d = prev_a_q;
        prev_b_d = prev_b_q;
        prev_c_d = prev_c_q;
        fill_d   = fill_q;
        fail_d   = fail_q;
        tap_d    = tap_q;
        mcnt_d   = mcnt_q;
        ccnt_d   = ccnt_q;
`ifdef SHIFT_CHK_TRACE_EN
        exp_d    = exp_q;
        act_d    = act_q;
`endif

        if (clear) begin
            // Clear wins over enable: the sample on this edge is discarded.
            state_d  = IDLE;
            prev_a_d = '0;
            prev_b_d = '0;
            prev_c_d = '0;
            fill_d   = '0;
            fail_d   = 1'b0;
            tap_d    = TAP_NONE;
            mcnt_d   = '0;
            ccnt_d   = '0;
`ifdef SHIFT_CHK_TRACE_EN
            exp_d    = '0;
            act_d    = '0;
`endif
        end else if (enable) begin
            prev_a_d = a;
            prev_b_d = b;
            prev_c_d = c;
            unique case (state_q)
                IDLE: begin
                    state_d = FILL;
                    fill_d  = FILL_W'(1);
                end
                FILL: begin
                    if (fill_q >= FILL_W'(FILL_CYC)) begin
                        state_d = CHECK;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                CHECK, FAIL: begin
                    if (!(&ccnt_q)) begin
                        ccnt_d = ccnt_q + CNT_W'(1);
                    end
                    if (any_mis) begin
                        state_d = FAIL;
                        if (!(&mcnt_q)) begin
                            mcnt_d = mcnt_q + CNT_W'(1);
                        end
                        // First failure only; later failures leave tap/data alone.
                        if (!fail_q) begin
                            fail_d = 1'b1;
                            tap_d  = lowest_tap(mis);
`ifdef SHIFT_CHK_TRACE_EN
                            if (mis[0]) begin
                                exp_d = prev_a_q;
                                act_d = b;
                            end else if (mis[1]) begin
                                exp_d = prev_b_q;
                                act_d = c;
                            end else begin
                                exp_d = prev_c_q;
                                act_d = d;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state.
        busy_d = (state_d == FILL) || (state_d == CHECK);
        pass_d = (state_d == CHECK) && !fail_d;
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_a_q <= '0;
            prev_b_q <= '0;
            prev_c_q <= '0;
            fill_q   <= '0;
            fail_q   <= 1'b0;
            tap_q    <= TAP_NONE;
            mcnt_q   <= '0;
            ccnt_q   <= '0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef SHIFT_CHK_TRACE_EN
            exp_q    <= '0;
            act_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
            prev_c_q <= prev_c_d;
            fill_q   <= fill_d;
            fail_q   <= fail_d;
            tap_q    <= tap_d;
            mcnt_q   <= mcnt_d;
            ccnt_q   <= ccnt_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
`ifdef SHIFT_CHK_TRACE_EN
            exp_q    <= exp_d;
            act_q    <= act_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign first_fail_tap = tap_q;
    assign mismatch_cnt   = mcnt_q;
    assign checked_cnt    = ccnt_q;
`ifdef SHIFT_CHK_TRACE_EN
    assign exp_val        = exp_q;
    assign act_val        = act_q;
`endif

endmodule

// File: tb/tb_shift_chain_checker.sv
// Scoreboard bench for shift_chain_checker: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after each clock (or reset) edge.
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
module tb_shift_chain_checker;
    import shift_chk_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW4 = 4;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic          clear  = 1'b0;
    logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;

    logic          busy, pass, fail;
    logic [1:0]    tap;
    logic [CW-1:0] mcnt, ccnt;
    logic          busy4, pass4, fail4;
    logic [1:0]    tap4;
    logic [CW4-1:0] mcnt4, ccnt4;
`ifdef SHIFT_CHK_TRACE_EN
    logic [W-1:0]  exp_val, act_val, exp_val4, act_val4;
`endif

    shift_chain_checker #(.WIDTH(W), .CNT_W(CW), .FILL_CYC(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .pass(pass), .fail(fail), .first_fail_tap(tap),
        .mismatch_cnt(mcnt), .checked_cnt(ccnt)
`ifdef SHIFT_CHK_TRACE_EN
        , .exp_val(exp_val), .act_val(act_val)
`endif
    );

    shift_chain_checker #(.WIDTH(W), .CNT_W(CW4), .FILL_CYC(1)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy4), .pass(pass4), .fail(fail4), .first_fail_tap(tap4),
        .mismatch_cnt(mcnt4), .checked_cnt(ccnt4)
`ifdef SHIFT_CHK_TRACE_EN
        , .exp_val(exp_val4), .act_val(act_val4)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          busy;
        logic          pass;
        logic          fail;
        logic [1:0]    tap;
        logic [CW-1:0] mcnt;
        logic [CW-1:0] ccnt;
        logic [W-1:0]  ev;
        logic [W-1:0]  av;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Expected outputs after the next edge, set by the stimulus before each step.
    logic          e_busy, e_pass, e_fail;
    logic [1:0]    e_tap;
    logic [CW-1:0] e_mcnt, e_ccnt;
    logic [W-1:0]  e_ev, e_av;

    function automatic logic [CW4-1:0] sat4(input logic [CW-1:0] x);
        return (x > CW'(15)) ? 4'hF : x[CW4-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    task automatic set_exp(input logic bz, input logic ps, input logic fl,
                           input logic [1:0] tp, input int mc, input int cc);
        e_busy = bz;
        e_pass = ps;
        e_fail = fl;
        e_tap  = tp;
        e_mcnt = CW'(mc);
        e_ccnt = CW'(cc);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.busy = e_busy;
        e.pass = e_pass;
        e.fail = e_fail;
        e.tap  = e_tap;
        e.mcnt = e_mcnt;
        e.ccnt = e_ccnt;
        e.ev   = e_ev;
        e.av   = e_av;
        return e;
    endfunction

    task automatic step(input logic en, input logic clr, input int ta, input int tb_v,
                        input int tc, input int td);
        @(negedge clock);
        enable = en;
        clear  = clr;
        a = W'(ta);
        b = W'(tb_v);
        c = W'(tc);
        d = W'(td);
        sb_q.push_back(snap());
    endtask

    task automatic chain(input int k);
        step(1'b1, 1'b0, k, k - 1, k - 2, k - 3);
    endtask

    // Monitor: compares one expectation per clock or async-reset edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or posedge reset);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("busy",  64'(busy), 64'(e.busy));
                chk("pass",  64'(pass), 64'(e.pass));
                chk("fail",  64'(fail), 64'(e.fail));
                chk("tap",   64'(tap),  64'(e.tap));
                chk("mcnt",  64'(mcnt), 64'(e.mcnt));
                chk("ccnt",  64'(ccnt), 64'(e.ccnt));
                chk("mcnt4", 64'(mcnt4), 64'(sat4(e.mcnt)));
                chk("ccnt4", 64'(ccnt4), 64'(sat4(e.ccnt)));
`ifdef SHIFT_CHK_TRACE_EN
                chk("exp_val", 64'(exp_val), 64'(e.ev));
                chk("act_val", 64'(act_val), 64'(e.av));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        e_ev = '0;
        e_av = '0;
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state; IDLE holds while disabled.
        step(1'b0, 1'b0, 1, 2, 3, 4);
        step(1'b0, 1'b0, 1, 2, 3, 4);

        // Correct chain for 100 cycles: pass from cycle 2's edge, 98 compares.
        for (int k = 1; k <= 100; k++) begin
            set_exp(1, (k >= 2), 0, TAP_NONE, 0, (k >= 3) ? k - 2 : 0);
            chain(k);
        end

        // Enable low for 5 cycles with taps frozen: nothing moves.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 100, 99, 98, 97);
        // Resume: compares against the last enabled sample.
        for (int k = 101; k <= 105; k++) begin
            set_exp(1, 1, 0, TAP_NONE, 0, k - 2);
            chain(k);
        end

        // Clear with enable high: sample discarded, back to IDLE.
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        step(1'b1, 1'b1, 106, 105, 104, 103);

        // Corrupt c where 9 is expected.
        for (int k = 1; k <= 10; k++) begin
            set_exp(1, (k >= 2), 0, TAP_NONE, 0, (k >= 3) ? k - 2 : 0);
            chain(k);
        end
        set_exp(0, 0, 1, TAP_C, 1, 9);
        e_ev = W'(9);
        e_av = W'(99);
        step(1'b1, 1'b0, 11, 10, 99, 8);
        // Chain faithfully carries 99 on to d: no new mismatch, compares continue.
        set_exp(0, 0, 1, TAP_C, 1, 10);
        step(1'b1, 1'b0, 12, 11, 10, 99);

        // b and d wrong on the same cycle: tap b reported, count +1.
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        e_ev = '0;
        e_av = '0;
        step(1'b1, 1'b1, 0, 0, 0, 0);
        set_exp(1, 0, 0, TAP_NONE, 0, 0);
        chain(1);
        set_exp(1, 1, 0, TAP_NONE, 0, 0);
        chain(2);
        set_exp(0, 0, 1, TAP_B, 1, 1);
        e_ev = W'(2);
        e_av = W'(1000);
        step(1'b1, 1'b0, 3, 1000, 1, 2000);
        // Next cycle c misses the bad b: count grows, first tap and data hold.
        set_exp(0, 0, 1, TAP_B, 2, 2);
        chain(4);

        // Async reset mid-CHECK, asserted between edges.
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        e_ev = '0;
        e_av = '0;
        step(1'b1, 1'b1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            set_exp(1, (k >= 2), 0, TAP_NONE, 0, (k >= 3) ? k - 2 : 0);
            chain(k);
        end
        @(negedge clock);
        a = W'(6);
        b = W'(5);
        c = W'(4);
        d = W'(3);
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        sb_q.push_back(snap());
        #2 reset = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_exp(1, (k >= 2), 0, TAP_NONE, 0, (k >= 3) ? k - 2 : 0);
            chain(k);
        end

        // 20 consecutive mismatches on b: 4-bit counters stop at 15.
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        step(1'b1, 1'b1, 0, 0, 0, 0);
        set_exp(1, 0, 0, TAP_NONE, 0, 0);
        step(1'b1, 1'b0, 0, 5, 5, 5);
        set_exp(1, 1, 0, TAP_NONE, 0, 0);
        step(1'b1, 1'b0, 0, 5, 5, 5);
        e_ev = '0;
        e_av = W'(5);
        for (int i = 1; i <= 20; i++) begin
            set_exp(0, 0, 1, TAP_B, i, i);
            step(1'b1, 1'b0, 0, 5, 5, 5);
        end

        // Clear with enable low still clears everything.
        set_exp(0, 0, 0, TAP_NONE, 0, 0);
        e_ev = '0;
        e_av = '0;
        step(1'b0, 1'b1, 0, 5, 5, 5);
        step(1'b0, 1'b0, 0, 5, 5, 5);

        repeat (3) @(negedge clock);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
